// File: rtl/cve2_pkg.sv
// Shared types and decode helpers for the static branch prediction controller.
package cve2_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
      logic        compressed;
   } bp_entry_t;

   typedef enum logic {
      BP_IDLE  = 1'b0,
      BP_REDIR = 1'b1
   } bp_state_e;

   // Control flow tracked by the predictor: JAL, BRANCH, C.J, C.JAL, C.BEQZ, C.BNEZ.
   function automatic logic is_cf(input logic [31:0] instr);
      logic cf;
      if (instr[1:0] == 2'b11) begin
         cf = (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_BRANCH);
      end else begin
         cf = (instr[1:0] == 2'b01) &&
              ((instr[15:13] == 3'b101) || (instr[15:13] == 3'b001) ||
               (instr[15:13] == 3'b110) || (instr[15:13] == 3'b111));
      end
      return cf;
   endfunction

endpackage

// File: rtl/cve2_branch_predict.sv
// Static predictor: jumps always taken, conditional branches taken when backward.
module cve2_branch_predict
   import cve2_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic        taken_o,
   output logic [31:0] target_o
);

   logic [31:0] imm_j, imm_b, imm_cj, imm_cb, imm;

   assign imm_j  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
   assign imm_b  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_cj = {{21{instr_i[12]}}, instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                    instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
   assign imm_cb = {{24{instr_i[12]}}, instr_i[6:5], instr_i[2], instr_i[11:10],
                    instr_i[4:3], 1'b0};

   always_comb begin
      taken_o = 1'b0;
      imm     = '0;
      if (instr_i[1:0] == 2'b11) begin
         if (instr_i[6:0] == OPC_JAL) begin
            taken_o = 1'b1;
            imm     = imm_j;
         end else if (instr_i[6:0] == OPC_BRANCH) begin
            taken_o = imm_b[31];
            imm     = imm_b;
         end
      end else if (instr_i[1:0] == 2'b01) begin
         case (instr_i[15:13])
            3'b001, 3'b101: begin
               taken_o = 1'b1;
               imm     = imm_cj;
            end
            3'b110, 3'b111: begin
               taken_o = imm_cb[31];
               imm     = imm_cb;
            end
            default: ;
         endcase
      end
      target_o = pc_i + imm;
   end

endmodule

// File: rtl/cve2_branch_predict_ctrl.sv
// Static branch prediction sequencer: fetch redirect, in-order tracking FIFO,
// resolution check with flush/correction PC, and saturating perf counters.
module cve2_branch_predict_ctrl
   import cve2_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             predict_en_i,
   input  logic             fetch_valid_i,
   input  logic             fetch_ready_i,
   input  logic [31:0]      fetch_rdata_i,
   input  logic [31:0]      fetch_pc_i,
   output logic             fetch_stall_o,
   output logic             redirect_req_o,
   output logic [31:0]      redirect_pc_o,
   input  logic             redirect_gnt_i,
   input  logic             resolve_valid_i,
   input  logic             resolve_taken_i,
   input  logic [31:0]      resolve_target_i,
   output logic             mispredict_o,
   output logic [31:0]      mispredict_pc_o,
   output logic [CNT_W-1:0] cnt_cf_o,
   output logic [CNT_W-1:0] cnt_mispred_o,
   output logic             protocol_err_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   bp_state_e        state_q;
   logic [31:0]      redirect_pc_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   bp_entry_t        fifo_q [DEPTH];
   bp_entry_t        head, new_entry;
   logic [CNT_W-1:0] cnt_cf_q, cnt_mispred_q;
   logic             mispredict_q, protocol_err_q;
   logic [31:0]      mispredict_pc_q;
   logic             bp_taken, pred_taken;
   logic [31:0]      bp_target;
   logic             empty, full, push, pop, mismatch, push_ok;

   cve2_branch_predict u_predict (
      .instr_i  (fetch_rdata_i),
      .pc_i     (fetch_pc_i),
      .taken_o  (bp_taken),
      .target_o (bp_target)
   );

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pred_taken = bp_taken & predict_en_i;

   assign fetch_stall_o = full | (state_q == BP_REDIR);
   assign push = fetch_valid_i & fetch_ready_i & ~fetch_stall_o & is_cf(fetch_rdata_i);
   assign pop  = resolve_valid_i & ~empty;
   assign head = fifo_q[rd_ptr_q[AW-1:0]];

   assign mismatch = pop & ((resolve_taken_i != head.taken) |
                            (resolve_taken_i & (resolve_target_i != head.target)));
   // A flush discards whatever fetch is handing over in the same cycle.
   assign push_ok  = push & ~mismatch;

   assign new_entry = '{pc:         fetch_pc_i,
                        target:     bp_target,
                        taken:      pred_taken,
                        compressed: (fetch_rdata_i[1:0] != 2'b11)};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= BP_IDLE;
         redirect_pc_q <= '0;
      end else if (mismatch) begin
         state_q <= BP_IDLE;
      end else begin
         unique case (state_q)
            BP_IDLE: begin
               if (push && pred_taken) begin
                  state_q       <= BP_REDIR;
                  redirect_pc_q <= bp_target;
               end
            end
            BP_REDIR: begin
               if (redirect_gnt_i) state_q <= BP_IDLE;
            end
            default: state_q <= BP_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) fifo_q[wr_ptr_q[AW-1:0]] <= new_entry;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         cnt_cf_q        <= '0;
         cnt_mispred_q   <= '0;
         mispredict_q    <= 1'b0;
         mispredict_pc_q <= '0;
         protocol_err_q  <= 1'b0;
      end else begin
         mispredict_q <= mismatch;
         if (mismatch) begin
            rd_ptr_q        <= wr_ptr_q;
            mispredict_pc_q <= resolve_taken_i ? resolve_target_i
                                               : head.pc + (head.compressed ? 32'd2 : 32'd4);
            if (cnt_mispred_q != '1) cnt_mispred_q <= cnt_mispred_q + CNT_W'(1);
         end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (cnt_cf_q != '1) cnt_cf_q <= cnt_cf_q + CNT_W'(1);
         end
         if (resolve_valid_i && empty) protocol_err_q <= 1'b1;
      end
   end

   assign redirect_req_o  = (state_q == BP_REDIR);
   assign redirect_pc_o   = redirect_pc_q;
   assign mispredict_o    = mispredict_q;
   assign mispredict_pc_o = mispredict_pc_q;
   assign cnt_cf_o        = cnt_cf_q;
   assign cnt_mispred_o   = cnt_mispred_q;
   assign protocol_err_o  = protocol_err_q;

endmodule

// File: tb/tb_cve2_branch_predict_ctrl.sv
// Bench for cve2_branch_predict_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_cve2_branch_predict_ctrl;

   localparam int DEPTH = 4;
   localparam int CNT_W = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        taken;
      logic        comp;
   } m_ent_t;

   logic             clk, rst_n;
   logic             predict_en, fv, fr, gnt, rv, rt;
   logic [31:0]      rdata, fpc, rtgt;
   logic             stall, req, mp, perr;
   logic [31:0]      rpc, mpc;
   logic [CNT_W-1:0] cnt_cf, cnt_mp;

   int n_checks = 0;
   int n_fail   = 0;

   cve2_branch_predict_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .predict_en_i     (predict_en),
      .fetch_valid_i    (fv),
      .fetch_ready_i    (fr),
      .fetch_rdata_i    (rdata),
      .fetch_pc_i       (fpc),
      .fetch_stall_o    (stall),
      .redirect_req_o   (req),
      .redirect_pc_o    (rpc),
      .redirect_gnt_i   (gnt),
      .resolve_valid_i  (rv),
      .resolve_taken_i  (rt),
      .resolve_target_i (rtgt),
      .mispredict_o     (mp),
      .mispredict_pc_o  (mpc),
      .cnt_cf_o         (cnt_cf),
      .cnt_mispred_o    (cnt_mp),
      .protocol_err_o   (perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] imm);
      return {imm[12], imm[10:5], 5'd1, 5'd2, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_cb(input logic [2:0] f3, input logic [31:0] imm);
      return {16'h0, f3, imm[8], imm[4:3], 3'd1, imm[7:6], imm[2:1], imm[5], 2'b01};
   endfunction

   function automatic logic [31:0] enc_cj(input logic [2:0] f3, input logic [31:0] imm);
      return {16'h0, f3, imm[11], imm[4], imm[9:8], imm[10], imm[6], imm[7], imm[3:1], imm[5], 2'b01};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      predict_en = 1'b1; fv = 1'b0; fr = 1'b1; gnt = 1'b0;
      rv = 1'b0; rt = 1'b0; rtgt = '0; rdata = 32'h0000_0013; fpc = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst_n = 1'b0;
      #3;
      n_checks++;
      if ({stall, req, rpc, mp, mpc, cnt_cf, cnt_mp, perr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h expected all zero",
                  {stall, req, rpc, mp, mpc, cnt_cf, cnt_mp, perr});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      n_checks++;
      if ({stall, req, mp, cnt_cf, cnt_mp, perr} !== '0) begin
         n_fail++;
         $display("FAIL reset_release got=%h expected all zero", {stall, req, mp, cnt_cf, cnt_mp, perr});
      end
   endtask

   task automatic test_backward_redirect;
      int nreq;
      do_reset();
      fv = 1'b1; rdata = enc_b(3'b000, -32'sd8); fpc = 32'h100;
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL redir_pre_stall got=%b exp=0", stall); end
      step();
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         if (req !== 1'b1) break;
         nreq++;
         n_checks++;
         if (rpc !== 32'hF8 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_hold pc=%h stall=%b exp pc=000000f8 stall=1", rpc, stall);
         end
         gnt = (nreq == 3);
         if (nreq == 3) fv = 1'b0;
         step();
         gnt = 1'b0;
      end
      n_checks++;
      if (nreq != 3) begin n_fail++; $display("FAIL redir_req_cycles got=%0d exp=3", nreq); end
      n_checks++;
      if (req !== 1'b0 || stall !== 1'b0 || cnt_cf !== 32'd1) begin
         n_fail++;
         $display("FAIL redir_after_gnt req=%b stall=%b cnt_cf=%0d exp 0 0 1", req, stall, cnt_cf);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      fv = 1'b1; rdata = enc_b(3'b000, -32'sd8); fpc = 32'h100;
      step();
      fv = 1'b0;
      n_checks++;
      if (req !== 1'b1) begin n_fail++; $display("FAIL areset_pre_req got=%b exp=1", req); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (req !== 1'b0 || stall !== 1'b0 || cnt_cf !== 32'd0 || rpc !== 32'd0) begin
         n_fail++;
         $display("FAIL areset_mid_redir req=%b stall=%b cnt_cf=%0d pc=%h exp all zero", req, stall, cnt_cf, rpc);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_forward_mispredict;
      do_reset();
      fv = 1'b1; rdata = enc_b(3'b001, 32'd64); fpc = 32'h200;
      step();
      fv = 1'b0;
      n_checks++;
      if (req !== 1'b0) begin n_fail++; $display("FAIL fwd_no_redirect got=%b exp=0", req); end
      rv = 1'b1; rt = 1'b1; rtgt = 32'h240;
      step();
      rv = 1'b0;
      n_checks++;
      if (mp !== 1'b1 || mpc !== 32'h240 || cnt_mp !== 32'd1) begin
         n_fail++;
         $display("FAIL fwd_mispredict mp=%b pc=%h cnt=%0d exp 1 00000240 1", mp, mpc, cnt_mp);
      end
      rv = 1'b1;
      step();
      rv = 1'b0;
      n_checks++;
      if (mp !== 1'b0 || perr !== 1'b1) begin
         n_fail++;
         $display("FAIL fwd_flush_empty mp=%b perr=%b exp mp=0 perr=1", mp, perr);
      end
   endtask

   task automatic test_compressed_mispredict;
      do_reset();
      fv = 1'b1; rdata = enc_cb(3'b110, -32'sd16); fpc = 32'h300;
      step();
      fv = 1'b0;
      n_checks++;
      if (req !== 1'b1 || rpc !== 32'h2F0) begin
         n_fail++;
         $display("FAIL cbeqz_redirect req=%b pc=%h exp 1 000002f0", req, rpc);
      end
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      rv = 1'b1; rt = 1'b0; rtgt = $urandom();
      step();
      rv = 1'b0;
      n_checks++;
      if (mp !== 1'b1 || mpc !== 32'h302) begin
         n_fail++;
         $display("FAIL cbeqz_mispredict mp=%b pc=%h exp 1 00000302", mp, mpc);
      end
   endtask

   task automatic test_full_stall;
      do_reset();
      fv = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         rdata = enc_b(3'b000, 32'd8); fpc = 32'h800 + 32'(4 * i);
         n_checks++;
         if (stall !== 1'b0) begin n_fail++; $display("FAIL full_fill_stall idx=%0d got=%b exp=0", i, stall); end
         step();
      end
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got=%b exp=1", stall); end
      step();
      n_checks++;
      if (cnt_cf !== 32'(DEPTH)) begin n_fail++; $display("FAIL full_no_push got=%0d exp=%0d", cnt_cf, DEPTH); end
      rv = 1'b1; rt = 1'b0; rtgt = '0;
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall_with_resolve got=%b exp=1", stall); end
      fv = 1'b0;
      step();
      rv = 1'b0;
      n_checks++;
      if (stall !== 1'b0 || mp !== 1'b0 || cnt_mp !== 32'd0) begin
         n_fail++;
         $display("FAIL full_after_pop stall=%b mp=%b cnt_mp=%0d exp 0 0 0", stall, mp, cnt_mp);
      end
   endtask

   task automatic test_flush_vs_push;
      do_reset();
      fv = 1'b1; rdata = enc_b(3'b001, 32'd64); fpc = 32'h400;
      step();
      rdata = enc_j(-32'sd16); fpc = 32'h404;
      step();
      n_checks++;
      if (req !== 1'b1 || rpc !== 32'h3F4) begin
         n_fail++;
         $display("FAIL flush_redir_setup req=%b pc=%h exp 1 000003f4", req, rpc);
      end
      rv = 1'b1; rt = 1'b1; rtgt = 32'h500;
      step();
      rv = 1'b0; fv = 1'b0;
      n_checks++;
      if (req !== 1'b0 || mp !== 1'b1 || mpc !== 32'h500 || cnt_cf !== 32'd2 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_redir req=%b mp=%b pc=%h cnt_cf=%0d stall=%b exp 0 1 00000500 2 0",
                  req, mp, mpc, cnt_cf, stall);
      end
      fv = 1'b1; rdata = enc_b(3'b001, 32'd64); fpc = 32'h600;
      step();
      rdata = enc_j(-32'sd16); fpc = 32'h604;
      rv = 1'b1; rt = 1'b1; rtgt = 32'h700;
      step();
      fv = 1'b0; rv = 1'b0;
      n_checks++;
      if (req !== 1'b0 || mp !== 1'b1 || mpc !== 32'h700 || cnt_cf !== 32'd3 || cnt_mp !== 32'd2) begin
         n_fail++;
         $display("FAIL flush_push req=%b mp=%b pc=%h cnt_cf=%0d cnt_mp=%0d exp 0 1 00000700 3 2",
                  req, mp, mpc, cnt_cf, cnt_mp);
      end
      rv = 1'b1;
      step();
      rv = 1'b0;
      n_checks++;
      if (perr !== 1'b1) begin n_fail++; $display("FAIL flush_push_dropped perr=%b exp=1", perr); end
   endtask

   task automatic test_predict_disable;
      do_reset();
      predict_en = 1'b0;
      fv = 1'b1; rdata = enc_j(-32'sd32); fpc = 32'h700;
      step();
      fv = 1'b0;
      n_checks++;
      if (req !== 1'b0 || stall !== 1'b0 || cnt_cf !== 32'd1) begin
         n_fail++;
         $display("FAIL pdis_no_redirect req=%b stall=%b cnt_cf=%0d exp 0 0 1", req, stall, cnt_cf);
      end
      rv = 1'b1; rt = 1'b1; rtgt = 32'h6E0;
      step();
      rv = 1'b0;
      n_checks++;
      if (mp !== 1'b1 || mpc !== 32'h6E0 || perr !== 1'b0) begin
         n_fail++;
         $display("FAIL pdis_entry_not_taken mp=%b pc=%h perr=%b exp 1 000006e0 0", mp, mpc, perr);
      end
      rv = 1'b1;
      step();
      rv = 1'b0;
      n_checks++;
      if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_set got=%b exp=1", perr); end
      repeat (5) step();
      n_checks++;
      if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got=%b exp=1", perr); end
      do_reset();
      n_checks++;
      if (perr !== 1'b0) begin n_fail++; $display("FAIL perr_reset got=%b exp=0", perr); end
   endtask

   task automatic test_random(input int n);
      m_ent_t      mq[$];
      bit          m_redir, m_err;
      logic [31:0] m_rpc;
      int unsigned m_cf, m_mp;
      do_reset();
      m_redir = 0; m_err = 0; m_rpc = '0; m_cf = 0; m_mp = 0;
      for (int c = 0; c < n; c++) begin
         int          kind, off;
         bit          cf, ptk, comp, stall_e, push_e, pop_e, mis_e;
         logic [31:0] ins, r, mpc_e;
         m_ent_t      h;
         predict_en = ($urandom_range(0, 9) != 0);
         fv   = 1'($urandom_range(0, 1));
         fr   = ($urandom_range(0, 3) != 0);
         fpc  = $urandom() & ~32'h1;
         kind = int'($urandom_range(0, 7));
         r    = $urandom();
         cf = 1; ptk = 0; off = 0; comp = (kind >= 4);
         case (kind)
            0: begin cf = 0; ins = 32'h00a0_0093; end
            1: begin cf = 0; ins = {r[31:16], 16'h0001}; end
            2: begin off = int'($urandom_range(0, 4095)) * 2 - 4096;
                     ins = enc_b(r[2:0], 32'(off)); ptk = (off < 0); end
            3: begin off = int'($urandom_range(0, 65535)) * 2 - 65536;
                     ins = enc_j(32'(off)); ptk = 1; end
            4: begin off = int'($urandom_range(0, 2047)) * 2 - 2048;
                     ins = enc_cj(3'b101, 32'(off)); ptk = 1; end
            5: begin off = int'($urandom_range(0, 2047)) * 2 - 2048;
                     ins = enc_cj(3'b001, 32'(off)); ptk = 1; end
            6: begin off = int'($urandom_range(0, 255)) * 2 - 256;
                     ins = enc_cb(3'b110, 32'(off)); ptk = (off < 0); end
            default: begin off = int'($urandom_range(0, 255)) * 2 - 256;
                     ins = enc_cb(3'b111, 32'(off)); ptk = (off < 0); end
         endcase
         if (comp) ins = {r[31:16], ins[15:0]};
         rdata = ins;
         rv = ($urandom_range(0, 9) < 4);
         if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
            rt   = mq[0].taken;
            rtgt = mq[0].taken ? mq[0].tgt : $urandom();
         end else begin
            rt   = 1'($urandom_range(0, 1));
            rtgt = $urandom();
         end
         gnt = ($urandom_range(0, 2) == 0);

         stall_e = (mq.size() == DEPTH) || m_redir;
         n_checks++;
         if (stall !== stall_e) begin
            n_fail++;
            $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall, stall_e);
         end
         push_e = fv && fr && !stall_e && cf;
         pop_e  = rv && (mq.size() > 0);
         mis_e  = 0; mpc_e = '0;
         if (pop_e) begin
            h     = mq[0];
            mis_e = (rt != h.taken) || (rt && rtgt != h.tgt);
            mpc_e = rt ? rtgt : h.pc + (h.comp ? 32'd2 : 32'd4);
         end
         step();

         if (rv && mq.size() == 0) m_err = 1;
         if (mis_e) begin
            mq.delete();
            m_redir = 0;
            m_mp++;
         end else begin
            if (m_redir && gnt) m_redir = 0;
            if (pop_e) void'(mq.pop_front());
            if (push_e) begin
               mq.push_back('{pc: fpc, tgt: fpc + 32'(off), taken: ptk && predict_en, comp: comp});
               m_cf++;
               if (ptk && predict_en) begin
                  m_redir = 1;
                  m_rpc   = fpc + 32'(off);
               end
            end
         end

         n_checks++;
         if (req !== m_redir || (m_redir && rpc !== m_rpc)) begin
            n_fail++;
            $display("FAIL rnd_redirect cyc=%0d req=%b pc=%h exp req=%b pc=%h", c, req, rpc, m_redir, m_rpc);
         end
         n_checks++;
         if (mp !== mis_e || (mis_e && mpc !== mpc_e)) begin
            n_fail++;
            $display("FAIL rnd_mispredict cyc=%0d mp=%b pc=%h exp mp=%b pc=%h", c, mp, mpc, mis_e, mpc_e);
         end
         n_checks++;
         if (cnt_cf !== CNT_W'(m_cf) || cnt_mp !== CNT_W'(m_mp) || perr !== m_err) begin
            n_fail++;
            $display("FAIL rnd_counters cyc=%0d cf=%0d mp=%0d perr=%b exp cf=%0d mp=%0d perr=%b",
                     c, cnt_cf, cnt_mp, perr, m_cf, m_mp, m_err);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b1;
      test_reset();
      test_backward_redirect();
      test_async_reset();
      test_forward_mispredict();
      test_compressed_mispredict();
      test_full_stall();
      test_flush_vs_push();
      test_predict_disable();
      test_random(600);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
